// File: rtl/cu_command_arbiter_pkg.sv
// Shared types for the CU command arbiter: command line, buffer status, grant and stats.
// The stats struct is only instantiated when CU_CMD_ARB_STATS_EN is defined.
package cu_command_arbiter_pkg;

    localparam int CMD_FIFO_DEPTH_DEFAULT     = 16;
    localparam int CMD_FIFO_AF_MARGIN_DEFAULT = 4;
    localparam int CREDIT_BITS_DEFAULT        = 8;

    typedef struct packed {
        logic        valid;
        logic [12:0] command;
        logic [7:0]  tag;
        logic [63:0] address;
    } CommandBufferLine;

    typedef struct packed {
        logic empty;
        logic alfull;
        logic full;
        logic valid;
    } BufferStatus;

    localparam BufferStatus BUFFER_STATUS_RESET = '{empty: 1'b1, alfull: 1'b0, full: 1'b0, valid: 1'b0};

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } CmdArbGrant;

    typedef struct packed {
        logic [63:0] read_issued;
        logic [63:0] write_issued;
        logic [63:0] stall;
    } CmdArbStats;

endpackage

// File: rtl/cu_command_arbiter_if.sv
// Command/status bundle between the CU control block, the arbiter and the PSL side.
// Stats ports exist only when CU_CMD_ARB_STATS_EN is defined.
interface cu_command_arbiter_if #(
    parameter int CREDIT_BITS = 8
);
    import cu_command_arbiter_pkg::*;

    logic                   enabled_in;
    logic [CREDIT_BITS-1:0] croom_in;
    CommandBufferLine       read_command_in;
    CommandBufferLine       write_command_in;
    logic                   credit_return_in;

    BufferStatus            read_buffer_status;
    BufferStatus            write_buffer_status;
    CommandBufferLine       command_out;
    logic [CREDIT_BITS-1:0] credits_out;
    logic                   read_overflow;
    logic                   write_overflow;
`ifdef CU_CMD_ARB_STATS_EN
    logic [63:0]            read_issued_count;
    logic [63:0]            write_issued_count;
    logic [63:0]            stall_cycles;
`endif

    modport slave (
        input  enabled_in, croom_in, read_command_in, write_command_in, credit_return_in,
        output read_buffer_status, write_buffer_status, command_out, credits_out,
               read_overflow, write_overflow
`ifdef CU_CMD_ARB_STATS_EN
        , output read_issued_count, write_issued_count, stall_cycles
`endif
    );

    modport master (
        output enabled_in, croom_in, read_command_in, write_command_in, credit_return_in,
        input  read_buffer_status, write_buffer_status, command_out, credits_out,
               read_overflow, write_overflow
`ifdef CU_CMD_ARB_STATS_EN
        , input read_issued_count, write_issued_count, stall_cycles
`endif
    );

endinterface

// File: rtl/cu_command_fifo.sv
// Synchronous command FIFO with registered status and a sticky overflow flag.
// An empty FIFO passes the incoming line straight to data_o so a same-cycle pop sees it.
module cu_command_fifo
    import cu_command_arbiter_pkg::*;
#(
    parameter int DEPTH     = CMD_FIFO_DEPTH_DEFAULT,
    parameter int AF_MARGIN = CMD_FIFO_AF_MARGIN_DEFAULT
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             push_i,
    input  CommandBufferLine data_i,
    input  logic             pop_i,
    input  logic             status_valid_i,
    output CommandBufferLine data_o,
    output logic             nonempty_o,
    output BufferStatus      status_o,
    output logic             overflow_o
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          AF_INT   = DEPTH - AF_MARGIN;
    localparam logic [AW:0] DEPTH_W  = DEPTH[AW:0];
    localparam logic [AW:0] AF_LEVEL = AF_INT[AW:0];
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    CommandBufferLine mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [AW:0]      count;
    logic             push_ok;
    BufferStatus      status_q;
    logic             overflow_q;

    // Pointer MSB separates full from empty when the low bits match.
    assign count      = wptr_q - rptr_q;
    assign nonempty_o = (count != '0);
    assign push_ok    = push_i & ((count != DEPTH_W) | pop_i);
    assign data_o     = nonempty_o ? mem_q[rptr_q[AW-1:0]] : data_i;
    assign status_o   = status_q;
    assign overflow_o = overflow_q;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            status_q   <= BUFFER_STATUS_RESET;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            overflow_q      <= overflow_q | (push_i & ~push_ok);
            status_q.empty  <= (count == '0);
            status_q.alfull <= (count >= AF_LEVEL);
            status_q.full   <= (count == DEPTH_W);
            status_q.valid  <= status_valid_i;
        end
    end

endmodule

// File: rtl/cu_command_arbiter.sv
// Buffers CU read/write commands and round-robins them onto the PSL command stream under credit control.
// Define CU_CMD_ARB_STATS_EN to add issued/stall 64-bit counters.
module cu_command_arbiter
    import cu_command_arbiter_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH     = CMD_FIFO_DEPTH_DEFAULT,
    parameter int CMD_FIFO_AF_MARGIN = CMD_FIFO_AF_MARGIN_DEFAULT,
    parameter int CREDIT_BITS        = CREDIT_BITS_DEFAULT
) (
    input  logic                 clock,
    input  logic                 rstn,
    cu_command_arbiter_if.slave  bus
);
    localparam logic [CREDIT_BITS-1:0] CREDIT_ONE = {{(CREDIT_BITS-1){1'b0}}, 1'b1};

    CommandBufferLine       rd_in_q;
    CommandBufferLine       wr_in_q;
    CommandBufferLine       cmd_q;
    CommandBufferLine       rd_head;
    CommandBufferLine       wr_head;
    logic                   enabled_q;
    logic [CREDIT_BITS-1:0] credits_q;
    logic [CREDIT_BITS-1:0] credits_d;
    logic [CREDIT_BITS-1:0] croom_q;
    CmdArbGrant             last_grant_q;

    logic load;
    logic can_issue;
    logic rd_push;
    logic wr_push;
    logic rd_nonempty;
    logic wr_nonempty;
    logic rd_req;
    logic wr_req;
    logic grant_rd;
    logic grant_wr;
    logic issue;
    logic credit_ret;

    // Issue is held off on the credit-load cycle so the loaded value is never decremented early.
    assign load       = bus.enabled_in & ~enabled_q;
    assign can_issue  = bus.enabled_in & ~load & (credits_q != '0);
    assign credit_ret = bus.credit_return_in & bus.enabled_in & ~load;
    assign rd_push    = bus.enabled_in & rd_in_q.valid;
    assign wr_push    = bus.enabled_in & wr_in_q.valid;
    assign rd_req     = can_issue & (rd_nonempty | rd_push);
    assign wr_req     = can_issue & (wr_nonempty | wr_push);
    assign grant_wr   = wr_req & (~rd_req | (last_grant_q == GRANT_READ));
    assign grant_rd   = rd_req & ~grant_wr;
    assign issue      = grant_rd | grant_wr;

    cu_command_fifo #(
        .DEPTH     (CMD_FIFO_DEPTH),
        .AF_MARGIN (CMD_FIFO_AF_MARGIN)
    ) u_rd_fifo (
        .clock          (clock),
        .rstn           (rstn),
        .push_i         (rd_push),
        .data_i         (rd_in_q),
        .pop_i          (grant_rd),
        .status_valid_i (bus.enabled_in),
        .data_o         (rd_head),
        .nonempty_o     (rd_nonempty),
        .status_o       (bus.read_buffer_status),
        .overflow_o     (bus.read_overflow)
    );

    cu_command_fifo #(
        .DEPTH     (CMD_FIFO_DEPTH),
        .AF_MARGIN (CMD_FIFO_AF_MARGIN)
    ) u_wr_fifo (
        .clock          (clock),
        .rstn           (rstn),
        .push_i         (wr_push),
        .data_i         (wr_in_q),
        .pop_i          (grant_wr),
        .status_valid_i (bus.enabled_in),
        .data_o         (wr_head),
        .nonempty_o     (wr_nonempty),
        .status_o       (bus.write_buffer_status),
        .overflow_o     (bus.write_overflow)
    );

    always_comb begin
        credits_d = credits_q;
        if (load) begin
            credits_d = bus.croom_in;
        end else if (issue && !credit_ret) begin
            credits_d = credits_q - CREDIT_ONE;
        end else if (credit_ret && !issue && (credits_q < croom_q)) begin
            credits_d = credits_q + CREDIT_ONE;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            rd_in_q      <= '0;
            wr_in_q      <= '0;
            cmd_q        <= '0;
            enabled_q    <= 1'b0;
            credits_q    <= '0;
            croom_q      <= '0;
            last_grant_q <= GRANT_READ;
        end else begin
            rd_in_q       <= bus.read_command_in;
            rd_in_q.valid <= bus.enabled_in & bus.read_command_in.valid;
            wr_in_q       <= bus.write_command_in;
            wr_in_q.valid <= bus.enabled_in & bus.write_command_in.valid;
            enabled_q     <= bus.enabled_in;
            credits_q     <= credits_d;
            if (load) begin
                croom_q <= bus.croom_in;
            end
            cmd_q.valid <= 1'b0;
            if (issue) begin
                cmd_q        <= grant_wr ? wr_head : rd_head;
                cmd_q.valid  <= 1'b1;
                last_grant_q <= grant_wr ? GRANT_WRITE : GRANT_READ;
            end
        end
    end

    assign bus.command_out = cmd_q;
    assign bus.credits_out = credits_q;

`ifdef CU_CMD_ARB_STATS_EN
    CmdArbStats stats_q;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            stats_q <= '0;
        end else begin
            if (grant_rd) begin
                stats_q.read_issued <= stats_q.read_issued + 64'd1;
            end
            if (grant_wr) begin
                stats_q.write_issued <= stats_q.write_issued + 64'd1;
            end
            if ((rd_nonempty || wr_nonempty) && (credits_q == '0)) begin
                stats_q.stall <= stats_q.stall + 64'd1;
            end
        end
    end

    assign bus.read_issued_count  = stats_q.read_issued;
    assign bus.write_issued_count = stats_q.write_issued;
    assign bus.stall_cycles       = stats_q.stall;
`endif

endmodule
